// File: rtl/sc_mlp_stream_engine.sv
// Two-layer stochastic MUX network run sequentially over a 2^LW-cycle bitstream,
// with per-output ones counters and argmax class selection.
module sc_mlp_stream_engine #(
  parameter int unsigned N0 = 16,
  parameter int unsigned K1 = 5,
  parameter int unsigned N1 = 8,
  parameter int unsigned K2 = 4,
  parameter int unsigned N2 = 4,
  parameter int unsigned LW = 8,
  parameter int unsigned CW = LW + 1,
  parameter int unsigned CIW = 2,
  parameter logic [K1-1:0] TAPS1 = K1'('h12),
  parameter logic [K1-1:0] SEED1 = K1'(1),
  parameter logic [K2-1:0] TAPS2 = K2'('h9),
  parameter logic [K2-1:0] SEED2 = K2'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             in_ready,
  input  logic [N0-1:0]    din,
  input  logic [N1*N0-1:0] w0,
  input  logic [N2*N1-1:0] w1,
  output logic             busy,
  output logic             done,
  output logic [N2*CW-1:0] count,
  output logic [CIW-1:0]   class_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [K1-1:0]   lfsr1, sel1;
  logic [K2-1:0]   lfsr2, sel2;
  logic [LW-1:0]   cyc;
  logic [N1-1:0]   s1, s1_nx;
  logic [N2-1:0]   s2, s2_nx;
  logic            v1, v2;
  logic [N2*CW-1:0] cnt;
  logic [CIW-1:0]  cls_q, cls_max;
  logic [CW-1:0]   best;

  function automatic logic [K1-1:0] step1(input logic [K1-1:0] s);
    return {s[K1-2:0], ^(s & TAPS1)};
  endfunction

  function automatic logic [K2-1:0] step2(input logic [K2-1:0] s);
    return {s[K2-2:0], ^(s & TAPS2)};
  endfunction

  assign sel1 = lfsr1 - K1'(1);
  assign sel2 = lfsr2 - K2'(1);

  // Select codes at or beyond the channel count match no j and contribute 0.
  always_comb begin
    s1_nx = '0;
    for (int unsigned i = 0; i < N1; i++) begin
      for (int unsigned j = 0; j < N0; j++) begin
        if (sel1 == K1'(j)) s1_nx[i] = din[j] & w0[i*N0+j];
      end
    end
  end

  always_comb begin
    s2_nx = '0;
    for (int unsigned k = 0; k < N2; k++) begin
      for (int unsigned i = 0; i < N1; i++) begin
        if (sel2 == K2'(i)) s2_nx[k] = s1[i] & w1[k*N1+i];
      end
    end
  end

  always_comb begin
    cls_max = '0;
    best    = cnt[CW-1:0];
    for (int unsigned k = 1; k < N2; k++) begin
      if (cnt[k*CW +: CW] > best) begin
        best    = cnt[k*CW +: CW];
        cls_max = CIW'(k);
      end
    end
  end

  // DRAIN ends once stage 1 has emptied; stage 2 flushes in that same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cyc == '1) state_nx = DRAIN;
      DRAIN:   if (!v1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      lfsr1 <= SEED1;
      lfsr2 <= SEED2;
      cyc   <= '0;
      s1    <= '0;
      s2    <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      cnt   <= '0;
      cls_q <= '0;
    end else begin
      state <= state_nx;
      v1    <= (state == RUN);
      v2    <= v1;
      if (state == RUN) begin
        s1    <= s1_nx;
        lfsr1 <= step1(lfsr1);
        cyc   <= cyc + LW'(1);
      end
      if (v1) begin
        s2    <= s2_nx;
        lfsr2 <= step2(lfsr2);
      end
      if (v2) begin
        for (int unsigned k = 0; k < N2; k++)
          cnt[k*CW +: CW] <= cnt[k*CW +: CW] + CW'(s2[k]);
      end
      if (state == DONE) cls_q <= cls_max;
      if (state == IDLE && start) begin
        cnt   <= '0;
        cyc   <= '0;
        lfsr1 <= SEED1;
        lfsr2 <= SEED2;
      end
    end
  end

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign count     = cnt;
  assign class_idx = (state == DONE) ? cls_max : cls_q;

endmodule

// File: tb/tb_sc_mlp_stream_engine.sv
// Bench for sc_mlp_stream_engine: a small directed instance and a default-size
// instance driven with random streams, both checked against a stream-level model.
module tb_sc_mlp_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_s, start_d;

  logic [2:0]  din_s;
  logic [8:0]  w0_s;
  logic [5:0]  w1_s;
  logic        in_ready_s, busy_s, done_s;
  logic [9:0]  count_s;
  logic        class_s;

  logic [15:0]  din_d;
  logic [127:0] w0_d;
  logic [31:0]  w1_d;
  logic         in_ready_d, busy_d, done_d;
  logic [35:0]  count_d;
  logic [1:0]   class_d;

  sc_mlp_stream_engine #(
    .N0(3), .K1(2), .N1(3), .K2(2), .N2(2), .LW(4), .CW(5), .CIW(1),
    .TAPS1(2'h3), .SEED1(2'h1), .TAPS2(2'h3), .SEED2(2'h1)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .in_ready(in_ready_s),
    .din(din_s), .w0(w0_s), .w1(w1_s), .busy(busy_s), .done(done_s),
    .count(count_s), .class_idx(class_s)
  );

  sc_mlp_stream_engine dut_d (
    .clk(clk), .reset(reset), .start(start_d), .in_ready(in_ready_d),
    .din(din_d), .w0(w0_d), .w1(w1_d), .busy(busy_d), .done(done_d),
    .count(count_d), .class_idx(class_d)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0]  din_a [256];
  logic [127:0] w0_a  [256];
  logic [31:0]  w1_a  [256];
  int exp_cnt [4];
  int exp_cls;

  function automatic int lfsr_step(input int s, input int taps, input int k);
    int fb;
    fb = $countones(s & taps) % 2;
    return ((s << 1) | fb) & ((1 << k) - 1);
  endfunction

  // Sample c uses the select codes after c LFSR steps; its layer-2 weight is the
  // w1 present one cycle later (held after the last run cycle).
  task automatic model(input int n0, input int k1, input int t1, input int n1,
                       input int k2, input int t2, input int n2, input int len);
    int l1, l2, sa, sb, wi;
    l1 = 1; l2 = 1;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    for (int c = 0; c < len; c++) begin
      sa = l1 - 1;
      sb = l2 - 1;
      wi = (c + 1 < len) ? c + 1 : len - 1;
      if (sa < n0 && sb < n1)
        for (int k = 0; k < n2; k++)
          exp_cnt[k] += int'(din_a[c][sa] & w0_a[c][sb*n0+sa] & w1_a[wi][k*n1+sb]);
      l1 = lfsr_step(l1, t1, k1);
      l2 = lfsr_step(l2, t2, k2);
    end
    exp_cls = 0;
    for (int k = 1; k < n2; k++)
      if (exp_cnt[k] > exp_cnt[exp_cls]) exp_cls = k;
  endtask

  task automatic fill_const(input logic [15:0] d, input logic [127:0] a, input logic [31:0] b);
    for (int c = 0; c < 256; c++) begin
      din_a[c] = d; w0_a[c] = a; w1_a[c] = b;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready_s, busy_s, done_s, count_s, class_s} !== '0) begin
      fails++;
      $display("FAIL reset_small: got %b required 0", {in_ready_s, busy_s, done_s, count_s, class_s});
    end
    tests++;
    if ({in_ready_d, busy_d, done_d, count_d, class_d} !== '0) begin
      fails++;
      $display("FAIL reset_default: got %h required 0", {in_ready_d, busy_d, done_d, count_d, class_d});
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  // extra: re-pulse start at t=5 and t=18; abort: assert reset during cycle t=8.
  task automatic run_small(input string name, input bit extra, input bit abort);
    int ndone;
    logic e_rdy, e_busy, e_done;
    model(3, 2, 3, 3, 2, 3, 2, 16);
    ndone = 0;
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    for (int t = 1; t <= 21; t++) begin
      if (t <= 16) begin
        din_s = din_a[t-1][2:0];
        w0_s  = w0_a[t-1][8:0];
        w1_s  = w1_a[t-1][5:0];
      end else begin
        din_s = 3'($urandom);
        w0_s  = 9'($urandom);
      end
      start_s = extra && (t == 5 || t == 18);
      reset   = !(abort && t == 8);
      @(negedge clk);
      if (done_s) ndone++;
      if (abort) begin
        if (t >= 9) begin
          tests++;
          if ({busy_s, done_s, in_ready_s} !== 3'b000) begin
            fails++;
            $display("FAIL %s_idle_t%0d: got busy/done/rdy=%b required 000", name, t, {busy_s, done_s, in_ready_s});
          end
        end
        if (t == 9) begin
          tests++;
          if (count_s !== '0) begin
            fails++;
            $display("FAIL %s_cleared: got %h required 0", name, count_s);
          end
        end
      end else begin
        e_rdy = (t <= 16); e_busy = (t <= 18); e_done = (t == 19);
        tests++;
        if ({in_ready_s, busy_s, done_s} !== {e_rdy, e_busy, e_done}) begin
          fails++;
          $display("FAIL %s_ctrl_t%0d: got rdy/busy/done=%b required %b", name, t,
                   {in_ready_s, busy_s, done_s}, {e_rdy, e_busy, e_done});
        end
        if (t == 19 || t == 21) begin
          tests++;
          if (count_s !== {5'(exp_cnt[1]), 5'(exp_cnt[0])} || class_s !== 1'(exp_cls)) begin
            fails++;
            $display("FAIL %s_result_t%0d: got c0=%0d c1=%0d cls=%0d required c0=%0d c1=%0d cls=%0d",
                     name, t, count_s[4:0], count_s[9:5], class_s, exp_cnt[0], exp_cnt[1], exp_cls);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (ndone != (abort ? 0 : 1)) begin
      fails++;
      $display("FAIL %s_done_pulses: got %0d required %0d", name, ndone, abort ? 0 : 1);
    end
    start_s = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic test_small_directed();
    fill_const('1, '1, '1);
    run_small("all_ones", 1'b0, 1'b0);
    fill_const('0, '1, '1);
    run_small("din_zero", 1'b0, 1'b0);
    fill_const('1, '1, 32'h38);
    run_small("class1", 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    fill_const('1, '1, 32'h38);
    run_small("restart_ignored", 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    fill_const('1, '1, 32'h38);
    run_small("abort", 1'b0, 1'b1);
    run_small("after_abort", 1'b0, 1'b0);
  endtask

  task automatic test_random_default();
    int stray;
    for (int n = 0; n < 50; n++) begin
      for (int c = 0; c < 256; c++) begin
        din_a[c] = 16'($urandom);
        w0_a[c]  = {$urandom, $urandom, $urandom, $urandom};
        w1_a[c]  = $urandom;
      end
      model(16, 5, 'h12, 8, 4, 'h9, 4, 256);
      stray = 0;
      @(posedge clk); #1 start_d = 1'b1;
      @(posedge clk); #1 start_d = 1'b0;
      for (int t = 1; t <= 260; t++) begin
        if (t <= 256) begin
          din_d = din_a[t-1]; w0_d = w0_a[t-1]; w1_d = w1_a[t-1];
        end else begin
          din_d = 16'($urandom); w0_d = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        if (t == 259) begin
          tests++;
          if (done_d !== 1'b1) begin
            fails++;
            $display("FAIL rand%0d_done: got %b required 1", n, done_d);
          end
          for (int k = 0; k < 4; k++) begin
            tests++;
            if (count_d[k*9 +: 9] !== 9'(exp_cnt[k])) begin
              fails++;
              $display("FAIL rand%0d_count%0d: got %0d required %0d", n, k, count_d[k*9 +: 9], exp_cnt[k]);
            end
          end
          tests++;
          if (class_d !== 2'(exp_cls)) begin
            fails++;
            $display("FAIL rand%0d_class: got %0d required %0d", n, class_d, exp_cls);
          end
        end else if (done_d !== 1'b0) begin
          stray++;
        end
        @(posedge clk); #1;
      end
      tests++;
      if (stray != 0) begin
        fails++;
        $display("FAIL rand%0d_stray_done: got %0d required 0", n, stray);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start_s = 1'b0; start_d = 1'b0;
    din_s = '0; w0_s = '0; w1_s = '0;
    din_d = '0; w0_d = '0; w1_d = '0;
    test_reset();
    test_small_directed();
    test_start_ignored();
    test_abort();
    test_random_default();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sc_mlp_stream_engine.md
Name: sc_mlp_stream_engine

Overview:
Sequential successor to the combinational two-layer stochastic-computing MUX network. It runs a full stochastic inference over a 2^LW-cycle bitstream and converts each output stream to a binary count. It also picks the winning class. It sits between the upstream stochastic number generators, which supply input and weight bits each cycle, and the classification readout logic. It uses per-layer internal LFSR select generation, a two-stage pipeline, a start/done handshake, and per-output accumulators.

Parameters:
N0, 16, input channel count.
K1, 5, layer-1 LFSR/select width; legal only if 2^K1-1 >= N0.
N1, 8, layer-1 neuron count.
K2, 4, layer-2 LFSR/select width; legal only if 2^K2-1 >= N1.
N2, 4, output neuron (class) count.
LW, 8, log2 of stream length L = 2^LW.
CW, LW+1, per-output count width.
CIW, 2, class index width; must satisfy 2^CIW >= N2.
TAPS1, K1'h12, layer-1 Fibonacci LFSR tap mask (maximal-length).
SEED1, 1, layer-1 LFSR reset/start seed; nonzero.
TAPS2, K2'h9, layer-2 tap mask (maximal-length).
SEED2, 1, layer-2 LFSR seed; nonzero.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  begin inference; sampled only in IDLE.
in_ready  out  1  high in RUN; upstream SNGs advance one bit per cycle where high.
din  in  N0  input stochastic bits for this cycle.
w0  in  N1*N0  layer-1 weight bits; neuron i, input j at bit i*N0+j.
w1  in  N2*N1  layer-2 weight bits; neuron k, input i at bit k*N1+i.
busy  out  1  high in RUN or DRAIN.
done  out  1  one-cycle pulse when results final.
count  out  N2*CW  output-k ones count at bits [k*CW +: CW].
class_idx  out  CIW  index of max count.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE; LFSR1=SEED1, LFSR2=SEED2.
  - Pipeline regs and valids 0; cycle counter 0.
  - count all 0; class_idx=0; busy=0; done=0; in_ready=0.
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 -> RUN; clears counts and cycle counter; reloads both LFSRs with their seeds.
  - RUN: lasts exactly L cycles. in_ready=1. Each cycle:
    - sel1 = LFSR1-1.
    - Layer-1 bit i = (sel1<N0) ? din[sel1] AND w0[i*N0+sel1] : 0, registered into s1[i]; v1=1.
    - LFSR1 steps; cycle counter increments. Counter == L-1 -> DRAIN.
  - Stage 2 (any state, when v1=1):
    - sel2 = LFSR2-1.
    - Output bit k = (sel2<N1) ? s1[sel2] AND w1[k*N1+sel2] : 0, registered into s2[k]; v2=1.
    - LFSR2 steps only when v1=1.
  - Accumulate: when v2=1, count[k] += s2[k]. CW=LW+1 guarantees no overflow (max L).
  - DRAIN: 2 cycles; v1 and v2 clear as the pipeline empties; then DONE.
  - DONE: one cycle. done=1; class_idx = argmax(count), lowest index wins ties; then IDLE.
- Latency: start sampled at edge ending cycle T -> done=1 in cycle T+L+3. count and class_idx are final in that cycle and held until the next accepted start.
- Scaling: each neuron output probability = sum(active products) / (2^K-1). Unused select codes (sel >= N) contribute 0.
- start in RUN, DRAIN or DONE is ignored; no queuing.
- Reset mid-operation aborts immediately to the reset state; no done pulse.
- din, w0 and w1 are ignored outside RUN.
- LFSR must never reach all-zero: seeds are nonzero, and taps are maximal-length.

Test Plan:
- Params N0=3,K1=2,N1=3,K2=2,N2=2,LW=4,CIW=1. din=all 1, w0=all 1, w1=all 1, pulse start at T -> in_ready high T+1..T+16; done only in T+19; count0=count1=16; class_idx=0 (tie).
- Same params, din=all 0 -> count0=count1=0, class_idx=0, done at T+19.
- din=all 1, w0=all 1, w1 neuron0=0 and neuron1=all 1 -> count0=0, count1=16, class_idx=1.
- Pulse start again at cycles T+5 and T+18 -> ignored; exactly one done; counts unchanged vs. the single-start result.
- Drive reset=0 at T+8 during RUN -> next cycle busy=0, counts 0, no done. A new start then gives the full 16-cycle result.
- Default params, random din/w0/w1 streams -> count and class_idx match the bit-exact reference model (same LFSR seeds/taps) over 50 inferences.
